// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker fetch front end: reset/halt constants
// and the {pc, instruction} entry carried through the fetch queue.
package tinker_pkg;

  localparam logic [4:0]  HALT_OP  = 5'h0f;
  localparam logic [63:0] RESET_PC = 64'h2000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring_buffer.sv
// Circular buffer of fetch entries with a synchronous flush.
// The head reads as all-zero whenever the buffer is empty.
module fetch_ring_buffer
  import tinker_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         head_valid,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Flush wins over any push or pop presented in the same cycle.
  assign do_push = push & ~flush;
  assign do_pop  = pop & (count_q != '0) & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_valid = (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/tinker_fetch_queue.sv
// Tinker instruction-fetch front end: owns the fetch PC and halt flag and
// streams {pc, instr} pairs to decode through a small ring buffer.
module tinker_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = tinker_pkg::RESET_PC,
  parameter logic [4:0]  HALT_OP  = tinker_pkg::HALT_OP
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_en,
  output logic [63:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic                   fetch_halted,
  output logic [$clog2(DEPTH):0] occupancy
);

  import tinker_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: decode takes the head on any cycle where out_valid and
  // out_ready are both high; out_* never change combinationally with out_ready.
  logic [63:0]   pc_q, pc_d;
  logic          halted_q, halted_d;
  logic          pop, push;
  logic [CW-1:0] count;
  fetch_entry_t  push_entry, head;

  assign pop  = out_valid & out_ready;
  assign push = ~reset & ~halted_q & ~redirect_valid & ((count < DEPTH_C) | pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_rdata;

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[63:2], 2'b00};
      halted_d = 1'b0;
    end else if (push) begin
      pc_d = pc_q + 64'd4;
      if (imem_rdata[31:27] == HALT_OP) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (out_valid),
    .head       (head),
    .count      (count)
  );

  assign imem_en      = push;
  assign imem_addr    = pc_q;
  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign fetch_halted = halted_q;
  assign occupancy    = count;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed and randomized bench for tinker_fetch_queue against a queue-based
// model of the fetch front end.
module tb_tinker_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h2000;
  localparam logic [4:0]  HALT   = 5'h0f;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_halted;
  logic [$clog2(DEPTH):0] occupancy;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory image controls
  logic [31:0] salt;
  logic        halt_en;
  logic [63:0] halt_addr;

  // Model state
  logic [95:0] exp_q[$];
  logic [63:0] m_pc;
  logic        m_halted;

  tinker_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_halted   (fetch_halted),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [63:0] a, input logic hen,
                                          input logic [63:0] ha, input logic [31:0] s);
    logic [31:0] w;
    w = (a[31:0] * 32'h9E37_79B1) ^ s;
    if (w[31:27] == HALT) w[31:27] = 5'h10;
    if (hen && a == ha) w[31:27] = HALT;
    return w;
  endfunction

  always_comb imem_rdata = word_at(imem_addr, halt_en, halt_addr, salt);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [95:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : 96'd0;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("out_pc", out_pc, h[95:32]);
    chk("out_instr", out_instr, h[31:0]);
    chk("occupancy", occupancy, exp_q.size());
    chk("fetch_halted", fetch_halted, m_halted);
    chk("imem_addr", imem_addr, m_pc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = RST_PC;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_en", imem_en, 1'b0);
    check_outputs();
    reset = 1'b0;
  endtask

  // One clock cycle: drive, check fetch enable, advance the model, check state.
  task automatic step(input logic redir, input logic [63:0] rpc, input logic rdy);
    logic        popped, exp_en;
    logic [31:0] w;
    redirect_valid = redir;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
    popped = (exp_q.size() > 0) && rdy;
    exp_en = !m_halted && !redir && ((exp_q.size() < DEPTH) || popped);
    chk("imem_en", imem_en, exp_en);
    if (redir) begin
      exp_q.delete();
      m_pc = {rpc[63:2], 2'b00};
      m_halted = 1'b0;
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (exp_en) begin
        w = word_at(m_pc, halt_en, halt_addr, salt);
        exp_q.push_back({m_pc, w});
        if (w[31:27] == HALT) m_halted = 1'b1;
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    salt = $urandom;
    halt_en = 1'b0;
    halt_addr = 64'd0;

    // Reset then free-run with decode always ready
    do_reset();
    step(1'b0, 64'd0, 1'b1);
    chk("first_pc", out_pc, 64'h2000);
    for (int i = 0; i < 8; i++) step(1'b0, 64'd0, 1'b1);

    // Decode stalls until the queue fills, then a pop and push in one cycle
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b0);
    chk("full_occ", occupancy, 4);
    chk("full_pc", imem_addr, 64'h2010);
    step(1'b0, 64'd0, 1'b1);
    chk("full_pushpop_occ", occupancy, 4);
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b1);

    // Redirect with three entries queued and ready high
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b0);
    chk("pre_redirect_occ", occupancy, 3);
    step(1'b1, 64'h3007, 1'b1);
    chk("redir_valid", out_valid, 1'b0);
    chk("redir_addr", imem_addr, 64'h3004);
    step(1'b0, 64'd0, 1'b1);
    chk("redir_out_pc", out_pc, 64'h3004);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1);

    // Halt word at 0x2008, then restart via redirect
    halt_en = 1'b1;
    halt_addr = 64'h2008;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b1);
    chk("halted", fetch_halted, 1'b1);
    chk("halted_pc", imem_addr, 64'h200c);
    step(1'b1, 64'h2000, 1'b1);
    chk("unhalted", fetch_halted, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1);
    halt_en = 1'b0;

    // Asynchronous reset mid-stream with two entries queued
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 64'd0, 1'b0);
    chk("pre_async_occ", occupancy, 2);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_occ", occupancy, 0);
    chk("async_addr", imem_addr, 64'h2000);
    chk("async_en", imem_en, 1'b0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1);

    // Randomized traffic with occasional redirects and halts
    for (int blk = 0; blk < 6; blk++) begin
      halt_en = ($urandom_range(0, 1) == 1);
      halt_addr = 64'h2000 + 64'($urandom_range(0, 40)) * 64'd4;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 11) == 0)
          step(1'b1, 64'h2000 + 64'($urandom_range(0, 200)), 1'($urandom_range(0, 1)));
        else
          step(1'b0, 64'd0, ($urandom_range(0, 3) != 0));
      end
    end

    // PC wrap at the top of the address space
    halt_en = 1'b0;
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
